csv_sfifo_fwft: RTL and testbench
=================================

# csv_sfifo_fwft

Parametrised synchronous first-word-fall-through FIFO built around an internal single-clock 1R1W memory with a registered read port, matching SRAM macro timing. It succeeds the basic RAM-backed CSV FIFO with:
- any DEPTH ≥ 2, not only powers of two;
- a full-width occupancy count;
- valid/ready read handshake with head data always presented;
- programmable almost-full and almost-empty flags;
- optional sticky error flags.

It sits between the CSV byte producers and consumers in the streaming datapath.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 32, total capacity in entries; ≥ 2, any integer
- ADDR_WIDTH, $clog2(DEPTH), memory address width
- AFULL_TH, DEPTH-2, o_almost_full threshold; 1..DEPTH
- AEMPTY_TH, 1, o_almost_empty threshold; 0..DEPTH-1
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- wdata  in  WIDTH  write data
- i_wreq  in  1  write request
- o_wready  out  1  write ready, = ~o_full
- rdata  out  WIDTH  head-of-queue data, valid when o_rvalid
- o_rvalid  out  1  head data valid
- i_rreq  in  1  pop request
- o_count  out  ADDR_WIDTH+1  entries accepted and not yet popped, 0..DEPTH
- o_full  out  1  o_count == DEPTH
- o_empty  out  1  o_count == 0
- o_almost_full  out  1  o_count ≥ AFULL_TH
- o_almost_empty  out  1  o_count ≤ AEMPTY_TH
- i_err_clr  in  1  clears sticky error flags
- o_overflow  out  1  sticky: write attempted while full
- o_underflow  out  1  sticky: pop attempted while !o_rvalid

## Operation
- **Write:** push = i_wreq & o_wready. The word is stored at the write pointer and the pointer increments. Wrap: at DEPTH-1 the pointer goes to 0, never to DEPTH.
- **Pop:** pop = i_rreq & o_rvalid. It consumes the head word.
- **Output stage:** the memory read-data register is the output stage.
  - A memory read is issued at an edge when at least one word is stored in the memory but not yet loaded into the output stage, and either o_rvalid=0 or a pop occurs.
  - The read pointer increments on each issued read, with the same wrap rule as the write pointer.
  - The output register holds its value when no read is issued.
- **o_rvalid:** set by an issued read; cleared by a pop with no read issued.
- **Count:** o_count +1 on push only, −1 on pop only, unchanged on both or neither. Full/empty/almost flags are combinational compares on o_count.
- **Collisions:** the read address never equals the write address on a push edge; an issued read implies stored unread data and a push implies not full.
- **Ignored requests:** i_wreq while full is ignored (no state change). i_rreq while !o_rvalid is ignored.
- **Reset values:** pointers, o_count, o_rvalid, error flags and rdata reset to 0. Consequently o_empty=1, o_almost_empty=1, o_wready=1, and all other outputs are 0. Memory contents are not reset.
- **Reset mid-operation:** all queued data is discarded, outputs return to reset values immediately, and no push or pop is performed on the reset edge.

## Timing
- Write-to-read latency into an empty FIFO:
  - push at edge k → o_count=1 after edge k;
  - read issued at edge k+1 → o_rvalid=1, rdata valid after edge k+1.
- Throughput is 1 push and 1 pop per cycle sustained. Pop at edge j with more stored data → next word on rdata after edge j, with o_rvalid staying 1.
- Simultaneous push and pop at o_count=DEPTH is impossible, because o_wready=0. At o_count=1 with o_rvalid=1, both occur: count stays 1, o_rvalid drops for one cycle, then the new word appears.
- o_wready depends only on registered state; there is no combinational path from i_rreq.

## Configuration
- CSV_SFIFO_FWFT_ERR_EN defined:
  - o_overflow is set on i_wreq & o_full;
  - o_underflow is set on i_rreq & ~o_rvalid;
  - both hold until i_err_clr=1 at an edge;
  - set wins over clear in the same cycle.
- CSV_SFIFO_FWFT_ERR_EN undefined: o_overflow and o_underflow are tied to 0, i_err_clr is ignored, and no flag registers exist.
- The port list is identical in both builds.

## Test plan
- Reset, then a single write of 0xA5 at edge 1 → o_count=1 after edge 1; o_rvalid=1 and rdata=0xA5 after edge 2; a pop at edge 3 → o_empty=1.
- DEPTH=5: 5 writes of 1..5 → o_full=1, o_wready=0; a 6th write is dropped; pops return 1..5 in order. Repeat 3 times to cover pointer wrap at a non-power-of-two depth.
- Continuous push+pop for 64 cycles after priming with 2 words → o_count constant at 2, output sequence matches input, no o_rvalid gap.
- AFULL_TH=4, AEMPTY_TH=1: fill 0→5 → o_almost_empty deasserts at count 2, o_almost_full asserts at count 4.
- With CSV_SFIFO_FWFT_ERR_EN:
  - write while full → o_overflow=1, held until i_err_clr;
  - pop while empty → o_underflow=1;
  - without the macro, both stay 0.
- Assert resetn low mid-stream at count 3 → all outputs at reset values immediately; after release, the first new write appears on rdata 2 edges later.

Source files
------------

// File: rtl/csv_sfifo_fwft.sv
// csv_sfifo_fwft: synchronous first-word-fall-through FIFO. Storage is a
// single-clock 1R1W memory whose registered read port is the output stage.
// Ports: clk, resetn (async active-low); write side wdata/i_wreq/o_wready;
// read side rdata/o_rvalid/i_rreq; status o_count, o_full, o_empty,
// o_almost_full, o_almost_empty; errors i_err_clr, o_overflow, o_underflow.
// Optional feature macro: CSV_SFIFO_FWFT_ERR_EN enables the sticky error flags.
module csv_sfifo_fwft #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int AFULL_TH   = DEPTH - 2,
   parameter int AEMPTY_TH  = 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  i_wreq,
   output logic                  o_wready,
   output logic [WIDTH-1:0]      rdata,
   output logic                  o_rvalid,
   input  logic                  i_rreq,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   input  logic                  i_err_clr,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AFULL_TH);
   localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_TH);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         unread;
   logic                  rvalid;
   logic [WIDTH-1:0]      rdata_q;
   logic                  push;
   logic                  pop;
   logic                  rd;

   assign o_full         = (count == FULL_C);
   assign o_empty        = (count == '0);
   assign o_almost_full  = (count >= AF_C);
   assign o_almost_empty = (count <= AE_C);
   assign o_wready       = ~o_full;
   assign o_count        = count;
   assign o_rvalid       = rvalid;
   assign rdata          = rdata_q;

   assign push = i_wreq & ~o_full;
   assign pop  = i_rreq & rvalid;

   // Words still in memory: the output stage holds one of the counted
   // entries whenever rvalid is set.
   assign unread = count - CW'(rvalid);
   assign rd     = (unread != '0) & (~rvalid | pop);

   // Memory array is not reset; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (push && resetn)
         mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         rvalid  <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (push)
            wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
         if (rd) begin
            rptr    <= (rptr == LAST) ? '0 : rptr + 1'b1;
            rdata_q <= mem[rptr];
            rvalid  <= 1'b1;
         end else if (pop) begin
            rvalid  <= 1'b0;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef CSV_SFIFO_FWFT_ERR_EN
   logic ovf_q;
   logic unf_q;

   // Setting takes priority over a same-cycle clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (i_wreq && o_full)
            ovf_q <= 1'b1;
         else if (i_err_clr)
            ovf_q <= 1'b0;
         if (i_rreq && !rvalid)
            unf_q <= 1'b1;
         else if (i_err_clr)
            unf_q <= 1'b0;
      end
   end

   assign o_overflow  = ovf_q;
   assign o_underflow = unf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = i_err_clr;
   assign o_overflow     = 1'b0;
   assign o_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_csv_sfifo_fwft.sv
// tb_csv_sfifo_fwft: directed bench for csv_sfifo_fwft (DEPTH=5) with a
// queue-based reference model checked every cycle plus literal expectations.
module tb_csv_sfifo_fwft;

   localparam int W   = 8;
   localparam int D   = 5;
   localparam int AW  = $clog2(D);
   localparam int AFT = 4;
   localparam int AET = 1;
`ifdef CSV_SFIFO_FWFT_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [W-1:0]  wdata = '0;
   logic          i_wreq = 1'b0;
   logic          o_wready;
   logic [W-1:0]  rdata;
   logic          o_rvalid;
   logic          i_rreq = 1'b0;
   logic [AW:0]   o_count;
   logic          o_full;
   logic          o_empty;
   logic          o_almost_full;
   logic          o_almost_empty;
   logic          i_err_clr = 1'b0;
   logic          o_overflow;
   logic          o_underflow;

   int checks = 0;
   int errors = 0;

   csv_sfifo_fwft #(
      .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW),
      .AFULL_TH(AFT), .AEMPTY_TH(AET)
   ) dut (
      .clk(clk), .resetn(resetn), .wdata(wdata),
      .i_wreq(i_wreq), .o_wready(o_wready), .rdata(rdata),
      .o_rvalid(o_rvalid), .i_rreq(i_rreq), .o_count(o_count),
      .o_full(o_full), .o_empty(o_empty),
      .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
      .i_err_clr(i_err_clr), .o_overflow(o_overflow),
      .o_underflow(o_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the queue holds every accepted, unpopped word;
   // m_rv says whether its head has reached the output stage.
   logic [W-1:0] q[$];
   bit m_rv = 1'b0;
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   always @(posedge clk or negedge resetn) begin
      bit mpush, mpop, mrd;
      int unread;
      if (!resetn) begin
         q.delete();
         m_rv  = 1'b0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         mpush  = i_wreq && (q.size() < D);
         mpop   = i_rreq && m_rv;
         unread = q.size() - int'(m_rv);
         mrd    = (unread > 0) && (!m_rv || mpop);
         if (ERR) begin
            if (i_wreq && q.size() == D) m_ovf = 1'b1;
            else if (i_err_clr)          m_ovf = 1'b0;
            if (i_rreq && !m_rv)         m_unf = 1'b1;
            else if (i_err_clr)          m_unf = 1'b0;
         end
         if (mpop)  void'(q.pop_front());
         if (mpush) q.push_back(wdata);
         if (mrd)        m_rv = 1'b1;
         else if (mpop)  m_rv = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (resetn) begin
         chk("m_count", int'(o_count), q.size());
         chk("m_full", int'(o_full), int'(q.size() == D));
         chk("m_empty", int'(o_empty), int'(q.size() == 0));
         chk("m_afull", int'(o_almost_full), int'(q.size() >= AFT));
         chk("m_aempty", int'(o_almost_empty), int'(q.size() <= AET));
         chk("m_wready", int'(o_wready), int'(q.size() != D));
         chk("m_rvalid", int'(o_rvalid), int'(m_rv));
         if (m_rv) chk("m_rdata", int'(rdata), int'(q[0]));
         chk("m_ovf", int'(o_overflow), int'(m_ovf));
         chk("m_unf", int'(o_underflow), int'(m_unf));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"}, int'(o_count), 0);
      chk({tag, "_rvalid"}, int'(o_rvalid), 0);
      chk({tag, "_rdata"}, int'(rdata), 0);
      chk({tag, "_empty"}, int'(o_empty), 1);
      chk({tag, "_aempty"}, int'(o_almost_empty), 1);
      chk({tag, "_wready"}, int'(o_wready), 1);
      chk({tag, "_full"}, int'(o_full), 0);
      chk({tag, "_afull"}, int'(o_almost_full), 0);
      chk({tag, "_ovf"}, int'(o_overflow), 0);
      chk({tag, "_unf"}, int'(o_underflow), 0);
   endtask

   initial begin
      int n;
      #2;
      chk_reset_vals("rst");
      step();
      step();
      resetn = 1'b1;

      // Single word latency
      wdata = 8'hA5; i_wreq = 1'b1;
      step();
      i_wreq = 1'b0;
      chk("lat_count", int'(o_count), 1);
      chk("lat_rv0", int'(o_rvalid), 0);
      step();
      chk("lat_rv1", int'(o_rvalid), 1);
      chk("lat_rdata", int'(rdata), 8'hA5);
      i_rreq = 1'b1;
      step();
      i_rreq = 1'b0;
      chk("lat_empty", int'(o_empty), 1);

      // Fill/drain at DEPTH=5, three rounds to wrap pointers
      for (int r = 0; r < 3; r++) begin
         for (int i = 1; i <= 5; i++) begin
            wdata = W'(i + 16 * r); i_wreq = 1'b1;
            step();
         end
         chk("fill_full", int'(o_full), 1);
         chk("fill_wready", int'(o_wready), 0);
         wdata = 8'hEE;
         step();
         i_wreq = 1'b0;
         chk("drop_count", int'(o_count), 5);
         chk("ovf_set", int'(o_overflow), int'(ERR));
         step();
         chk("ovf_hold", int'(o_overflow), int'(ERR));
         i_err_clr = 1'b1;
         step();
         i_err_clr = 1'b0;
         chk("ovf_clr", int'(o_overflow), 0);
         for (int i = 1; i <= 5; i++) begin
            chk("drain_rv", int'(o_rvalid), 1);
            chk("drain_data", int'(rdata), i + 16 * r);
            i_rreq = 1'b1;
            step();
         end
         i_rreq = 1'b0;
         chk("drain_empty", int'(o_empty), 1);
      end

      // Underflow
      i_rreq = 1'b1;
      step();
      i_rreq = 1'b0;
      chk("unf_set", int'(o_underflow), int'(ERR));
      i_err_clr = 1'b1;
      step();
      i_err_clr = 1'b0;
      chk("unf_clr", int'(o_underflow), 0);

      // Streaming: prime 2 words, then push+pop every cycle
      i_wreq = 1'b1;
      wdata = 8'd100;
      step();
      wdata = 8'd101;
      step();
      for (int i = 0; i < 64; i++) begin
         chk("str_count", int'(o_count), 2);
         chk("str_rv", int'(o_rvalid), 1);
         chk("str_data", int'(rdata), (100 + i) % 256);
         wdata = W'(102 + i); i_wreq = 1'b1; i_rreq = 1'b1;
         step();
      end
      i_wreq = 1'b0;
      n = 0;
      while (!o_empty && n < 20) begin
         step();
         n++;
      end
      i_rreq = 1'b0;
      chk("str_drained", int'(o_empty), 1);

      // Threshold flags from 0 to 5
      chk("th_ae0", int'(o_almost_empty), 1);
      for (int k = 1; k <= 5; k++) begin
         wdata = W'(k); i_wreq = 1'b1;
         step();
         chk("th_count", int'(o_count), k);
         chk("th_ae", int'(o_almost_empty), int'(k <= 1));
         chk("th_af", int'(o_almost_full), int'(k >= 4));
      end
      i_wreq = 1'b0;
      i_rreq = 1'b1;
      n = 0;
      while (!o_empty && n < 20) begin
         step();
         n++;
      end
      i_rreq = 1'b0;
      chk("th_drained", int'(o_empty), 1);

      // Reset mid-stream at count 3
      for (int k = 0; k < 3; k++) begin
         wdata = W'(8'h50 + k); i_wreq = 1'b1;
         step();
      end
      i_wreq = 1'b0;
      chk("mid_count3", int'(o_count), 3);
      #2;
      resetn = 1'b0;
      #1;
      chk_reset_vals("mid");
      step();
      resetn = 1'b1;
      wdata = 8'h3C; i_wreq = 1'b1;
      step();
      i_wreq = 1'b0;
      chk("post_rv0", int'(o_rvalid), 0);
      step();
      chk("post_rv1", int'(o_rvalid), 1);
      chk("post_data", int'(rdata), 8'h3C);
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
